// File: rtl/ring_token_arbiter_pkg.sv
// Shared definitions for the ring token arbiter: FSM state encodings
// and default sizing for the requester count and hold limit.
package ring_token_arbiter_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OWN  = 1'b1;

    localparam int N_DEF        = 4;
    localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/ring_token_arbiter_token_ring.sv
// One-hot rotating token register holding the round-robin pointer.
// Ports: clk, clear (async preset of bit0), load, val (one-hot), ptr.
module token_ring
    import ring_token_arbiter_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] val,
    output logic [N-1:0] ptr
);

    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            ptr <= {{(N-1){1'b0}}, 1'b1};
        else if (load)
            ptr <= {val[N-2:0], val[N-1]};
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot token and a hold timeout.
// Ports: clk, clear (async reset), req[N], rel (owner release; `release`
// is a reserved word), grant[N], busy, owner[CW], timeout (revoke pulse).
module ring_token_arbiter
    import ring_token_arbiter_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [N-1:0]         req,
    input  logic                 rel,
    output logic [N-1:0]         grant,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 timeout
);

    localparam int CW = $clog2(N);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic          state;
    logic [HW-1:0] hold_cnt;
    logic [N-1:0]  ptr;
    logic [N-1:0]  pick;
    logic [CW-1:0] pick_idx;
    logic          found;
    logic          own_exit;
    logic          revoke;
    int            base;
    int            j;

    // First requester at or after the token position, wrapping.
    always_comb begin
        base = 0;
        for (int i = 0; i < N; i++)
            if (ptr[i]) base = i;
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        j        = 0;
        for (int i = 0; i < N; i++) begin
            j = (base + i) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = CW'(j);
            end
        end
    end

    // Voluntary exit wins over revoke so a coincident release is silent.
    logic vol_exit;
    assign vol_exit = rel || !req[owner];
    assign revoke   = (state == ST_OWN) && (hold_cnt == HOLD_LAST) && !vol_exit;
    assign own_exit = (state == ST_OWN) && (vol_exit || hold_cnt == HOLD_LAST);
    assign busy     = |grant;

    token_ring #(.N(N)) u_ring (
        .clk   (clk),
        .clear (clear),
        .load  (own_exit),
        .val   (grant),
        .ptr   (ptr)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant    <= pick;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        state    <= ST_OWN;
                    end
                end
                default: begin
                    if (own_exit) begin
                        grant    <= '0;
                        owner    <= '0;
                        hold_cnt <= '0;
                        timeout  <= revoke;
                        state    <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    a_ptr_onehot: assert property (@(posedge clk) disable iff (clear)
        $onehot(ptr));
    a_grant_onehot0: assert property (@(posedge clk) disable iff (clear)
        $onehot0(grant));
    a_owner_match: assert property (@(posedge clk) disable iff (clear)
        busy |-> grant[owner]);
    a_hold_bound: assert property (@(posedge clk) disable iff (clear)
        int'(hold_cnt) < MAX_HOLD);

endmodule
